iki_bit_adimli_carpici: RTL



---
 rtl/iki_bit_adimli_carpici.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/iki_bit_adimli_carpici.sv
// iki_bit_adimli_carpici
// Sequential radix-4 multiplier for the RV32M execute stage. It retires two
// multiplier bits per cycle on operand magnitudes and then applies the sign
// once, in the result cycle. It shares the istek/bitti handshake with the
// two-bit-step divider.
//
// Parameters:
//   HIZLI_SIFIR : 1 = a zero operand bypasses the 16 iterations
//
// Ports:
//   clk         : clock, rising edge
//   rst_g       : asynchronous active-low reset
//   a_g, b_g    : multiplicand (rs1) and multiplier (rs2)
//   istek       : start request, sampled only when idle
//   a_isaretli  : a_g is two's complement
//   b_isaretli  : b_g is two's complement
//   ust_yarim   : 1 returns product[63:32], 0 returns product[31:0]
//   sonuc       : selected product half, held until the next completion
//   carpim      : full 64-bit product, held until the next completion
//   mesgul      : high whenever the unit is not idle
//   bitti       : one-cycle completion pulse
module iki_bit_adimli_carpici #(
    parameter bit HIZLI_SIFIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_g,
    input  logic [31:0] a_g,
    input  logic [31:0] b_g,
    input  logic        istek,
    input  logic        a_isaretli,
    input  logic        b_isaretli,
    input  logic        ust_yarim,
    output logic [31:0] sonuc,
    output logic [63:0] carpim,
    output logic        mesgul,
    output logic        bitti
);

    typedef enum logic [1:0] {
        BOSTA,
        HESAPLA,
        SONUC
    } durum_t;

    durum_t      durum;
    logic [31:0] m;          // multiplicand magnitude
    logic [31:0] q;          // multiplier magnitude, shifts out as product low half
    logic [33:0] p;          // partial-product accumulator
    logic [3:0]  sayac;
    logic        negatif;
    logic        ust_sec;

    // Operand magnitudes. The unsigned 32-bit negation maps -2^31 to 2^31,
    // which is exactly the magnitude we need.
    logic        a_neg, b_neg;
    logic [31:0] a_mutlak, b_mutlak;
    logic        sifir_kisa;

    assign a_neg      = a_isaretli & a_g[31];
    assign b_neg      = b_isaretli & b_g[31];
    assign a_mutlak   = a_neg ? (~a_g + 32'd1) : a_g;
    assign b_mutlak   = b_neg ? (~b_g + 32'd1) : b_g;
    assign sifir_kisa = HIZLI_SIFIR && ((a_g == 32'd0) || (b_g == 32'd0));

    // One radix-4 step: pick 0/M/2M/3M by the low two multiplier bits.
    logic [33:0] m_genis;
    logic [33:0] kat;
    logic [33:0] toplam;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        m_genis = {2'b00, m};
        kat     = '0;
        unique case (q[1:0])
            2'b00: kat = '0;
            2'b01: kat = m_genis;
            2'b10: kat = m_genis << 1;
            2'b11: kat = m_genis + (m_genis << 1);
        endcase
        toplam = p + kat;
    end

    // Result cycle: sign applied to the 64-bit magnitude product.
    logic [63:0] mutlak_carpim;
    logic [63:0] isaretli_carpim;

    assign mutlak_carpim   = {p[31:0], q};
    assign isaretli_carpim = negatif ? (~mutlak_carpim + 64'd1) : mutlak_carpim;

    assign mesgul = (durum != BOSTA);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge rst_g) begin
        if (!rst_g) begin
            durum   <= BOSTA;
            m       <= '0;
            q       <= '0;
            p       <= '0;
            sayac   <= '0;
            negatif <= 1'b0;
            ust_sec <= 1'b0;
            sonuc   <= '0;
            carpim  <= '0;
            bitti   <= 1'b0;
        end else begin
            // bitti is a pulse: low unless the result cycle raises it below.
            bitti <= 1'b0;
            unique case (durum)
                BOSTA: begin
                    if (istek) begin
                        p       <= '0;
                        ust_sec <= ust_yarim;
                        durum   <= HESAPLA;
                        if (sifir_kisa) begin
                            // Zero product: one pass through HESAPLA on a zero
                            // multiplicand, then straight to the result cycle.
                            m       <= '0;
                            q       <= '0;
                            negatif <= 1'b0;
                            sayac   <= 4'd15;
                        end else begin
                            m       <= a_mutlak;
                            q       <= b_mutlak;
                            negatif <= a_neg ^ b_neg;
                            sayac   <= 4'd0;
                        end
                    end
                end

                HESAPLA: begin
                    // {P,Q} <= {P + d, Q} >> 2 as one 66-bit logical shift.
                    p     <= {2'b00, toplam[33:2]};
                    q     <= {toplam[1:0], q[31:2]};
                    sayac <= sayac + 4'd1;
                    if (sayac == 4'd15) begin
                        durum <= SONUC;
                    end
                end

                SONUC: begin
                    carpim <= isaretli_carpim;
                    sonuc  <= ust_sec ? isaretli_carpim[63:32] : isaretli_carpim[31:0];
                    bitti  <= 1'b1;
                    durum  <= BOSTA;
                end

                default: durum <= BOSTA;
            endcase
        end
    end

endmodule
